axon_scan_ctrl: RTL and testbench

AXON_SCAN_CTRL -- requirements
Module: axon_scan_ctrl

---
 rtl/axon_scan_ctrl_if.sv | 36 +++
 rtl/axon_scan_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_axon_scan_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/axon_scan_ctrl_if.sv
// rtl/axon_scan_ctrl_if.sv - start/stall handshake, spike buffer reads and returned spike stream of the axon scan controller
interface axon_scan_ctrl_if #(
   parameter int AXON_CNT_BIT_WIDTH = 8
);
   logic                          start_i;
   logic                          lrnEn_i;
   logic                          stall_i;
   logic [AXON_CNT_BIT_WIDTH-1:0] RclAxonAddr_o;
   logic                          rdEn_RclInSpike_o;
   logic                          saveRclSpikes_o;
   logic [AXON_CNT_BIT_WIDTH-1:0] LrnAxonAddr_o;
   logic                          rdEn_LrnInSpike_o;
   logic                          Rcl_InSpike_i;
   logic                          Lrn_InSpike_i;
   logic                          spkVld_o;
   logic                          spkBit_o;
   logic [AXON_CNT_BIT_WIDTH-1:0] spkAddr_o;
   logic                          spkLrn_o;
   logic [AXON_CNT_BIT_WIDTH:0]   rclSpkCnt_o;
   logic                          busy_o;
   logic                          done_o;

   modport slave (
      input  start_i, lrnEn_i, stall_i, Rcl_InSpike_i, Lrn_InSpike_i,
      output RclAxonAddr_o, rdEn_RclInSpike_o, saveRclSpikes_o, LrnAxonAddr_o,
             rdEn_LrnInSpike_o, spkVld_o, spkBit_o, spkAddr_o, spkLrn_o,
             rclSpkCnt_o, busy_o, done_o
   );

   modport master (
      output start_i, lrnEn_i, stall_i, Rcl_InSpike_i, Lrn_InSpike_i,
      input  RclAxonAddr_o, rdEn_RclInSpike_o, saveRclSpikes_o, LrnAxonAddr_o,
             rdEn_LrnInSpike_o, spkVld_o, spkBit_o, spkAddr_o, spkLrn_o,
             rclSpkCnt_o, busy_o, done_o
   );
endinterface

// File: rtl/axon_scan_ctrl.sv
// rtl/axon_scan_ctrl.sv - recall/learn axon sweep controller; learn phase built only when LRN_PHASE_EN is defined
module axon_scan_ctrl #(
   parameter int NUM_AXONS          = 256,
   parameter int AXON_CNT_BIT_WIDTH = 8
) (
   input logic             clk_i,
   input logic             rst_i,
   axon_scan_ctrl_if.slave bus
);
   localparam int W = AXON_CNT_BIT_WIDTH;
   localparam logic [W-1:0] LAST_ADDR = W'(NUM_AXONS - 1);
   localparam logic [W-1:0] ONE_ADDR  = W'(1);

`ifdef LRN_PHASE_EN
   typedef enum logic [2:0] {IDLE, RCL, RDRN, SAVE, LRN, LDRN, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, RCL, RDRN, DONE} state_t;
`endif

   state_t       state;
   logic [W-1:0] cnt;        // next address to issue in the active sweep
   logic [W-1:0] rclAddr;
   logic         rclRdEn;
   logic         spkVld;
   logic [W-1:0] spkAddr;
   logic [W:0]   rclSpkCnt;
   logic         busy;
   logic         done;
   logic         spkSrcBit;
   logic         rclHit;

`ifdef LRN_PHASE_EN
   logic         lrnLatched;
   logic [W-1:0] lrnAddr;
   logic         lrnRdEn;
   logic         saveSpk;
   logic         spkLrn;

   // buffer data arrives one cycle after its enable; pick the buffer that was read
   assign spkSrcBit = spkLrn ? bus.Lrn_InSpike_i : bus.Rcl_InSpike_i;
   assign rclHit    = spkVld & ~spkLrn & spkSrcBit;

   assign bus.LrnAxonAddr_o     = lrnAddr;
   assign bus.rdEn_LrnInSpike_o = lrnRdEn;
   assign bus.saveRclSpikes_o   = saveSpk;
   assign bus.spkLrn_o          = spkLrn;
`else
   logic unusedLrnIn;

   assign unusedLrnIn = ^{bus.lrnEn_i, bus.Lrn_InSpike_i};
   assign spkSrcBit   = bus.Rcl_InSpike_i;
   assign rclHit      = spkVld & spkSrcBit;

   assign bus.LrnAxonAddr_o     = '0;
   assign bus.rdEn_LrnInSpike_o = 1'b0;
   assign bus.saveRclSpikes_o   = 1'b0;
   assign bus.spkLrn_o          = 1'b0;
`endif

   assign bus.RclAxonAddr_o     = rclAddr;
   assign bus.rdEn_RclInSpike_o = rclRdEn;
   assign bus.spkVld_o          = spkVld;
   assign bus.spkBit_o          = spkVld & spkSrcBit;
   assign bus.spkAddr_o         = spkAddr;
   assign bus.rclSpkCnt_o       = rclSpkCnt;
   assign bus.busy_o            = busy;
   assign bus.done_o            = done;

   // sweep FSM: every output is a register updated on the edge that enters the cycle it describes
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         rclAddr   <= '0;
         rclRdEn   <= 1'b0;
         spkVld    <= 1'b0;
         spkAddr   <= '0;
         rclSpkCnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef LRN_PHASE_EN
         lrnLatched <= 1'b0;
         lrnAddr    <= '0;
         lrnRdEn    <= 1'b0;
         saveSpk    <= 1'b0;
         spkLrn     <= 1'b0;
`endif
      end else begin
         // enables and pulses default low; addresses fall back to 0 with their enable
         rclRdEn <= 1'b0;
         rclAddr <= '0;
         done    <= 1'b0;
`ifdef LRN_PHASE_EN
         lrnRdEn <= 1'b0;
         lrnAddr <= '0;
         saveSpk <= 1'b0;
         spkVld  <= rclRdEn | lrnRdEn;
         spkAddr <= rclAddr | lrnAddr;
         spkLrn  <= lrnRdEn;
`else
         spkVld  <= rclRdEn;
         spkAddr <= rclAddr;
`endif
         if (rclHit) begin
            rclSpkCnt <= rclSpkCnt + 1'b1;
         end

         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  state     <= RCL;
                  busy      <= 1'b1;
                  rclSpkCnt <= '0;
`ifdef LRN_PHASE_EN
                  lrnLatched <= bus.lrnEn_i;
`endif
                  if (!bus.stall_i) begin
                     rclRdEn <= 1'b1;
                     cnt     <= ONE_ADDR;
                  end else begin
                     cnt <= '0;
                  end
               end
            end
            RCL: begin
               if (rclRdEn && rclAddr == LAST_ADDR) begin
                  state <= RDRN;
               end else if (!bus.stall_i) begin
                  rclRdEn <= 1'b1;
                  rclAddr <= cnt;
                  cnt     <= cnt + 1'b1;
               end
            end
            RDRN: begin
`ifdef LRN_PHASE_EN
               if (lrnLatched) begin
                  state   <= SAVE;
                  saveSpk <= 1'b1;
                  cnt     <= '0;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
`else
               state <= DONE;
               done  <= 1'b1;
`endif
            end
`ifdef LRN_PHASE_EN
            SAVE: begin
               state <= LRN;
               if (!bus.stall_i) begin
                  lrnRdEn <= 1'b1;
                  cnt     <= ONE_ADDR;
               end
            end
            LRN: begin
               if (lrnRdEn && lrnAddr == LAST_ADDR) begin
                  state <= LDRN;
               end else if (!bus.stall_i) begin
                  lrnRdEn <= 1'b1;
                  lrnAddr <= cnt;
                  cnt     <= cnt + 1'b1;
               end
            end
            LDRN: begin
               state <= DONE;
               done  <= 1'b1;
            end
`endif
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
`ifdef LRN_PHASE_EN
               lrnLatched <= 1'b0;
`endif
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_axon_scan_ctrl.sv
// tb/tb_axon_scan_ctrl.sv - randomized scoreboard bench for axon_scan_ctrl
module tb_axon_scan_ctrl;
   localparam int N = 8;
   localparam int W = 4;
`ifdef LRN_PHASE_EN
   localparam bit LRN_BUILT = 1'b1;
`else
   localparam bit LRN_BUILT = 1'b0;
`endif

   typedef struct {
      int addr;
      bit b;
      bit lrn;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   nVec = 0;
   int   nErr = 0;
   int   doneCnt = 0;
   int   doneCyc = 0;
   int   rdCnt = 0;
   int   saveCnt = 0;
   int   expCnt = 0;
   exp_t sbQ[$];
   exp_t monE;
   logic [N-1:0] rclPat = '0;
   logic [N-1:0] lrnPat = '0;
   logic         pR = 1'b0;
   logic         pL = 1'b0;
   logic [W-1:0] pRA = '0;
   logic [W-1:0] pLA = '0;

   axon_scan_ctrl_if #(.AXON_CNT_BIT_WIDTH(W)) bus ();

   axon_scan_ctrl #(.NUM_AXONS(N), .AXON_CNT_BIT_WIDTH(W)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // cycle index: after posedge k the value read is k
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endfunction

   function automatic logic [63:0] outVec();
      return 64'({bus.RclAxonAddr_o, bus.rdEn_RclInSpike_o, bus.saveRclSpikes_o, bus.LrnAxonAddr_o,
                  bus.rdEn_LrnInSpike_o, bus.spkVld_o, bus.spkBit_o, bus.spkAddr_o, bus.spkLrn_o,
                  bus.rclSpkCnt_o, bus.busy_o, bus.done_o});
   endfunction

   // spike buffers: remember this cycle's reads, answer them in the next cycle
   always @(negedge clk) begin
      pR  = bus.rdEn_RclInSpike_o;
      pRA = bus.RclAxonAddr_o;
      pL  = bus.rdEn_LrnInSpike_o;
      pLA = bus.LrnAxonAddr_o;
   end

   always @(posedge clk) begin
      #1;
      bus.Rcl_InSpike_i = pR ? rclPat[pRA] : 1'($urandom_range(0, 1));
      bus.Lrn_InSpike_i = pL ? lrnPat[pLA] : 1'($urandom_range(0, 1));
   end

   // monitor: pops the scoreboard on every returned spike and checks interface rules
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.spkVld_o) begin
            if (sbQ.size() == 0) begin
               check("spk_unexpected", 64'd1, 64'd0);
            end else begin
               monE = sbQ.pop_front();
               check("spk_addr", 64'(bus.spkAddr_o), 64'(monE.addr));
               check("spk_bit", 64'(bus.spkBit_o), 64'(monE.b));
               check("spk_lrn", 64'(bus.spkLrn_o), 64'(monE.lrn));
            end
         end
         if (!bus.rdEn_RclInSpike_o) check("rcl_addr_idle_zero", 64'(bus.RclAxonAddr_o), 64'd0);
         if (!bus.rdEn_LrnInSpike_o) check("lrn_addr_idle_zero", 64'(bus.LrnAxonAddr_o), 64'd0);
         check("enables_exclusive",
               64'(32'(bus.rdEn_RclInSpike_o) + 32'(bus.rdEn_LrnInSpike_o) + 32'(bus.saveRclSpikes_o) > 1),
               64'd0);
         rdCnt   += int'(bus.rdEn_RclInSpike_o) + int'(bus.rdEn_LrnInSpike_o);
         saveCnt += int'(bus.saveRclSpikes_o);
         if (bus.done_o) begin
            doneCnt++;
            doneCyc = cyc;
            check("rcl_spike_count", 64'(bus.rclSpkCnt_o), 64'(expCnt));
            check("busy_in_done", 64'(bus.busy_o), 64'd1);
         end
      end
   end

   // one timestep; stallMode 0 none, 1 three cycles at address 3, 2 random; noise 0 none, 1 random, 2 constant start
   task automatic runSweep(input logic [N-1:0] pat, input bit lrnReq, input int stallMode,
                           input int noise, input int resetAt);
      bit learn;
      int d0;
      int stCyc;
      int stallLeft;
      bit stalled;
      bit aborted;
      bit hitReset;
      learn  = LRN_BUILT && lrnReq;
      rclPat = pat;
      lrnPat = N'($urandom);
      expCnt = $countones(pat);
      for (int a = 0; a < N; a++) sbQ.push_back('{addr: a, b: pat[a], lrn: 1'b0});
      if (learn) for (int a = 0; a < N; a++) sbQ.push_back('{addr: a, b: lrnPat[a], lrn: 1'b1});
      rdCnt = 0;
      saveCnt = 0;
      d0 = doneCnt;
      stallLeft = 0;
      stalled = 1'b0;
      aborted = 1'b0;
      @(posedge clk);
      #1;
      bus.lrnEn_i = lrnReq;
      bus.start_i = 1'b1;
      bus.stall_i = (stallMode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      stCyc = cyc;
      for (int k = 0; k < 6 * N + 40; k++) begin
         @(posedge clk);
         #1;
         if (doneCnt != d0) break;
         bus.lrnEn_i = 1'($urandom_range(0, 1));
         bus.start_i = (noise == 2) ? 1'b1 : (noise == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
         hitReset = learn ? (bus.rdEn_LrnInSpike_o && int'(bus.LrnAxonAddr_o) == resetAt)
                          : (bus.rdEn_RclInSpike_o && int'(bus.RclAxonAddr_o) == resetAt);
         if (resetAt >= 0 && hitReset) begin
            #2 rst = 1'b1;
            #1 check("async_reset_outputs", outVec(), 64'd0);
            sbQ.delete();
            aborted = 1'b1;
            break;
         end
         if (stallMode == 1) begin
            if (!stalled && bus.rdEn_RclInSpike_o && bus.RclAxonAddr_o == W'(2)) begin
               stallLeft = 3;
               stalled = 1'b1;
            end
            bus.stall_i = (stallLeft > 0);
            if (stallLeft > 0) stallLeft--;
         end else if (stallMode == 2) begin
            bus.stall_i = ($urandom_range(0, 3) == 0);
         end else begin
            bus.stall_i = 1'b0;
         end
      end
      bus.start_i = 1'b0;
      bus.stall_i = 1'b0;
      if (aborted) begin
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         return;
      end
      check("done_pulse_seen", 64'(doneCnt - d0), 64'd1);
      if (stallMode != 2)
         check("done_latency", 64'(doneCyc - stCyc),
               64'(N + 2 + (learn ? N + 2 : 0) + (stallMode == 1 ? 3 : 0)));
      check("read_count", 64'(rdCnt), 64'(learn ? 2 * N : N));
      check("save_pulses", 64'(saveCnt), 64'(learn ? 1 : 0));
      check("scoreboard_drained", 64'(sbQ.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", 64'(bus.busy_o), 64'd0);
      check("single_done", 64'(doneCnt - d0), 64'd1);
      sbQ.delete();
   endtask

   // stimulus sequence
   initial begin
      bus.start_i = 1'b0;
      bus.lrnEn_i = 1'b0;
      bus.stall_i = 1'b0;
      bus.Rcl_InSpike_i = 1'b0;
      bus.Lrn_InSpike_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", outVec(), 64'd0);
      rst = 1'b0;
      runSweep(8'hFF, 1'b0, 0, 0, -1);
      runSweep(8'hA5, 1'b1, 0, 0, -1);
      runSweep(N'($urandom), 1'b0, 1, 0, -1);
      runSweep(8'h5A, 1'b1, 0, 2, -1);
      runSweep(8'hFF, 1'b1, 0, 0, 5);
      runSweep(8'h3C, 1'b0, 0, 0, -1);
      for (int r = 0; r < 20; r++) begin
         runSweep(N'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 1)), -1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

   // hard stop in case a wait ever runs away
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
